ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
- Shares the single-port SoC data RAM between two requesters: the CPU load/store port and the UART DMA port.
- Arbitration is round-robin. The DMA side may hold a burst lock, bounded by a starvation limit.
- Read data returns with fixed latency to whichever requester owned the issuing cycle.
- Sits between the CPU, the UART and the RAM macro, replacing direct address muxing at SoC level.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_WAIT, 4, consecutive denied cycles after which the waiting requester is forced through (range 1..15)
RD_LAT, 1, RAM read latency in cycles (1 or 2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request
cpu_we  in  1  CPU write enable
cpu_addr  in  AW  CPU word address
cpu_wdata  in  DW  CPU write data
cpu_gnt  out  1  CPU access issued this cycle
cpu_rvalid  out  1  CPU read data valid
cpu_rdata  out  DW  CPU read data
dma_req  in  1  UART DMA request
dma_lock  in  1  hold grant for a burst
dma_we  in  1  DMA write enable
dma_addr  in  AW  DMA word address
dma_wdata  in  DW  DMA write data
dma_gnt  out  1  DMA access issued this cycle
dma_rvalid  out  1  DMA read data valid
dma_rdata  out  DW  DMA read data
ram_en  out  1  RAM access enable
ram_we  out  1  RAM write enable
ram_addr  out  AW  RAM address
ram_wdata  out  DW  RAM write data
ram_rdata  in  DW  RAM read data, valid RD_LAT cycles after a read issue

Behaviour:
- Reset (rst=1 at posedge):
  - state=RR, last=DMA (CPU wins the first tie), wait counters=0, pipeline tags cleared.
  - cpu_rvalid, dma_rvalid, cpu_rdata and dma_rdata are forced to 0; any in-flight read is discarded.
  - While rst=1, cpu_gnt, dma_gnt and ram_en are 0.
- Grants are combinational from the requests plus registered state.
  - At most one gnt is high per cycle; ram_en = cpu_gnt | dma_gnt.
  - ram_we, ram_addr and ram_wdata come from the granted side; with no grant they are all 0.
  - A request is accepted in the cycle its gnt is high. The requester must hold req and its fields stable until then.
- State RR:
  - Only one requester active: it is granted.
  - Both active: grant the side not equal to last.
  - last updates to the granted side on each grant.
  - dma_gnt with dma_lock=1 moves the state to LOCK.
- State LOCK:
  - dma_req granted every cycle, regardless of last.
  - A cpu_req in LOCK increments cpu_wait (saturating at MAX_WAIT); cpu_wait clears on any cpu_gnt.
  - When cpu_wait==MAX_WAIT and cpu_req=1, the CPU is granted that cycle and the DMA is held off. The lock persists.
  - Exit to RR on the cycle dma_lock=0 or dma_req=0; that cycle is arbitrated under RR rules.
- Starvation in RR:
  - dma_wait counts consecutive denied dma_req cycles.
  - With RR alternation it never exceeds 1; an assertion checks dma_wait<=1.
- Read return:
  - Per issued read, an owner tag (CPU or DMA) is shifted through an RD_LAT-deep pipeline.
  - At the output, the matching rvalid pulses for 1 cycle and the matching rdata is loaded from ram_rdata.
  - rdata holds its value until the next valid for that side.
  - Writes produce no rvalid.
- Throughput: one access per cycle, with no bubbles between owners.
- Same-address conflict: no ordering beyond grant order is guaranteed. A write granted in cycle N is visible to a read granted in cycle N+1.
- Reset asserted mid-burst or mid-read: state returns to RR in the following cycle and no stale rvalid is emitted.

Decomposition:
- Package soc_mem_pkg holds:
  - the owner_t enum {OWN_CPU, OWN_DMA};
  - the arb_state_t enum {RR, LOCK};
  - the mailbox address constants UART_CTRL_ADDR=411699, UART_EXC_ADDR=411698 and IMG_BASE_ADDR=206800, shared with the UART and the CPU firmware map.
- One sub-module, arb_wait_cnt: a saturating 4-bit wait counter with inc, clr and at_limit, instantiated once per requester.

Test Plan:
1. Reset, idle: rst high 3 cycles, then both requests 0 -> all gnt, rvalid and ram_en are 0; cpu_rdata=0 and dma_rdata=0.
2. Solo read: cpu_req read to addr 0x10, RAM word 0xDEADBEEF -> cpu_gnt same cycle, cpu_rvalid and cpu_rdata=0xDEADBEEF after RD_LAT; dma_rvalid stays 0.
3. Contention:
   - Both sides request continuously for 6 cycles starting from reset.
   - Required: grants go CPU, DMA, CPU, DMA, CPU, DMA.
   - Each rvalid returns to the correct side with its own address's data.
4. Lock starvation:
   - dma_lock=1 with dma_req held; cpu_req held from cycle 0, MAX_WAIT=4.
   - Required: DMA granted cycles 0-3, CPU granted cycle 4, DMA granted again cycle 5.
5. Lock exit: dma_lock deasserted in a cycle where both sides request and last=DMA -> CPU granted that cycle, state back to RR.
6. Reset mid-read: rst asserted the cycle after a DMA read is granted -> no dma_rvalid and no stale cpu_rvalid after reset releases; the next CPU write to 411699 with data 0 is granted normally.

Source files
------------

// File: rtl/soc_mem_pkg.sv
// Shared types and firmware-visible addresses for the SoC data RAM path.
package soc_mem_pkg;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  typedef enum logic {
    RR   = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  localparam int unsigned UART_CTRL_ADDR = 411699;
  localparam int unsigned UART_EXC_ADDR  = 411698;
  localparam int unsigned IMG_BASE_ADDR  = 206800;

  localparam int unsigned WaitCntW = 4;

endpackage

// File: rtl/arb_wait_cnt.sv
// Saturating wait counter: counts denied request cycles up to Limit, cleared on grant.
module arb_wait_cnt #(
  parameter int unsigned Limit = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       inc_i,
  input  logic       clr_i,
  output logic [3:0] cnt_o,
  output logic       at_limit_o
);

  localparam logic [3:0] LimitW = 4'(Limit);

  logic [3:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LimitW)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign at_limit_o = (cnt_q == LimitW);

endmodule

// File: rtl/ram_port_arbiter.sv
// CPU / UART-DMA arbiter for the single-port data RAM. Read data for an access issued in
// cycle N is presented on the owner's rvalid/rdata registers in cycle N+RD_LAT+1.
module ram_port_arbiter
  import soc_mem_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_lock,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam int unsigned Last = RD_LAT - 1;

  arb_state_t state_q, state_d;
  owner_t     last_q, last_d;

  logic       lock_active;
  logic       cpu_g, dma_g;
  logic [3:0] cpu_wait, dma_wait;
  logic       cpu_at_limit, dma_at_limit;

  logic [RD_LAT-1:0] tag_vld_q;
  owner_t            tag_own_q [RD_LAT];
  logic              cpu_rvalid_q, dma_rvalid_q;
  logic [DW-1:0]     cpu_rdata_q, dma_rdata_q;

  // The lock only holds while the DMA keeps both req and lock up; otherwise RR rules apply.
  assign lock_active = (state_q == LOCK) && dma_req && dma_lock;

  always_comb begin
    cpu_g = 1'b0;
    dma_g = 1'b0;
    if (!rst) begin
      if (lock_active) begin
        if (cpu_req && cpu_at_limit) begin
          cpu_g = 1'b1;
        end else begin
          dma_g = 1'b1;
        end
      end else if (dma_req && dma_at_limit) begin
        dma_g = 1'b1;
      end else if (cpu_req && dma_req) begin
        if (last_q == OWN_DMA) begin
          cpu_g = 1'b1;
        end else begin
          dma_g = 1'b1;
        end
      end else begin
        cpu_g = cpu_req;
        dma_g = dma_req;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (cpu_g) begin
      last_d = OWN_CPU;
    end else if (dma_g) begin
      last_d = OWN_DMA;
    end
    if (lock_active || (dma_g && dma_lock)) begin
      state_d = LOCK;
    end else begin
      state_d = RR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RR;
      last_q  <= OWN_DMA;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  arb_wait_cnt #(
    .Limit (MAX_WAIT)
  ) u_cpu_wait (
    .clk_i      (clk),
    .rst_i      (rst),
    .inc_i      (lock_active && cpu_req && !cpu_g),
    .clr_i      (cpu_g),
    .cnt_o      (cpu_wait),
    .at_limit_o (cpu_at_limit)
  );

  arb_wait_cnt #(
    .Limit (MAX_WAIT)
  ) u_dma_wait (
    .clk_i      (clk),
    .rst_i      (rst),
    .inc_i      (dma_req && !dma_g),
    .clr_i      (dma_g),
    .cnt_o      (dma_wait),
    .at_limit_o (dma_at_limit)
  );

  assign cpu_gnt = cpu_g;
  assign dma_gnt = dma_g;
  assign ram_en  = cpu_g | dma_g;

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (cpu_g) begin
      ram_we    = cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else if (dma_g) begin
      ram_we    = dma_we;
      ram_addr  = dma_addr;
      ram_wdata = dma_wdata;
    end
  end

  // Owner tags ride alongside the RAM's read latency so data returns to the issuing side.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_own_q[i] <= OWN_CPU;
      end
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      tag_vld_q[0] <= ram_en && !ram_we;
      tag_own_q[0] <= dma_g ? OWN_DMA : OWN_CPU;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_own_q[i] <= tag_own_q[i-1];
      end
      cpu_rvalid_q <= tag_vld_q[Last] && (tag_own_q[Last] == OWN_CPU);
      dma_rvalid_q <= tag_vld_q[Last] && (tag_own_q[Last] == OWN_DMA);
      if (tag_vld_q[Last] && (tag_own_q[Last] == OWN_CPU)) begin
        cpu_rdata_q <= ram_rdata;
      end
      if (tag_vld_q[Last] && (tag_own_q[Last] == OWN_DMA)) begin
        dma_rdata_q <= ram_rdata;
      end
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign dma_rvalid = dma_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dma_rdata  = dma_rdata_q;

  gnt_onehot_a: assert property (@(posedge clk) !(cpu_g && dma_g));
  dma_wait_a:   assert property (@(posedge clk) disable iff (rst) dma_wait <= 4'd1);
  cpu_wait_a:   assert property (@(posedge clk) disable iff (rst) cpu_wait <= 4'(MAX_WAIT));

endmodule
